// File: rtl/mem_access.sv
// Memory-stage access controller: issues one data-memory bus request per
// load/store, stalls the pipeline until it completes, and resolves CBZ branches.
module mem_access #(
    parameter int unsigned N       = 64,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memRead_M,
    input  logic         memWrite_M,
    input  logic         Branch_M,
    input  logic         zero_M,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] writeData_M,
    output logic         PCSrc_M,
    output logic [N-1:0] readData_M,
    output logic         stall,
    output logic         mem_err,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ready,
    input  logic [N-1:0] dm_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N-1:0]     addr_nxt, wdata_nxt, rdata_nxt;
    logic             we_nxt, err_nxt, stall_c;
    logic             access_c, illegal_c;

    assign PCSrc_M   = Branch_M & zero_M;
    assign access_c  = memRead_M | memWrite_M;
    assign illegal_c = (memRead_M & memWrite_M) | (aluResult_M[2:0] != 3'b000);

    // State is already IDLE during reset; stall is gated so the pipeline is released at once
    assign dm_req = (state == REQ);
    assign stall  = reset & stall_c;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = dm_addr;
        wdata_nxt = dm_wdata;
        we_nxt    = dm_we;
        rdata_nxt = readData_M;
        err_nxt   = mem_err;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                stall_c = access_c;
                if (access_c) begin
                    if (illegal_c) begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = REQ;
                        addr_nxt  = aluResult_M;
                        wdata_nxt = writeData_M;
                        we_nxt    = memWrite_M;
                        cnt_nxt   = '0;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (dm_ready) begin
                    state_nxt = DONE;
                    if (!dm_we) begin
                        rdata_nxt = dm_rdata;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    // Counter reaching TIMEOUT-1 means TIMEOUT-1 unanswered REQ cycles
                    if (cnt == CNT_W'(TIMEOUT - 2)) begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            ERR: begin
                stall_c = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
            dm_we      <= 1'b0;
            readData_M <= '0;
            mem_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dm_addr    <= addr_nxt;
            dm_wdata   <= wdata_nxt;
            dm_we      <= we_nxt;
            readData_M <= rdata_nxt;
            mem_err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: load, store with waits, misalignment,
// timeout, branch and mid-access reset.
module tb_mem_access;

    localparam int unsigned N       = 64;
    localparam int unsigned TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         memRead_M, memWrite_M, Branch_M, zero_M;
    logic [N-1:0] aluResult_M, writeData_M;
    logic         PCSrc_M, stall, mem_err, dm_req, dm_we, dm_ready;
    logic [N-1:0] readData_M, dm_addr, dm_wdata, dm_rdata;

    int total = 0;
    int bad   = 0;

    mem_access #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .memRead_M  (memRead_M),
        .memWrite_M (memWrite_M),
        .Branch_M   (Branch_M),
        .zero_M     (zero_M),
        .aluResult_M(aluResult_M),
        .writeData_M(writeData_M),
        .PCSrc_M    (PCSrc_M),
        .readData_M (readData_M),
        .stall      (stall),
        .mem_err    (mem_err),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_ready   (dm_ready),
        .dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        memRead_M = 1'b0; memWrite_M = 1'b0; Branch_M = 1'b0; zero_M = 1'b0;
        aluResult_M = '0; writeData_M = '0; dm_ready = 1'b0; dm_rdata = '0;
        #1;
        chk("rst_dm_req", 64'(dm_req), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_mem_err", 64'(mem_err), 64'd0);
        chk("rst_rdata", readData_M, 64'h0);
        chk("rst_addr", dm_addr, 64'h0);
        tick();
        reset = 1'b1;
        tick();

        // Zero-wait load
        dm_ready = 1'b1; dm_rdata = 64'hABCD; memRead_M = 1'b1; aluResult_M = 64'h10;
        #1;
        chk("ld_idle_stall", 64'(stall), 64'd1);
        chk("ld_idle_req", 64'(dm_req), 64'd0);
        tick();
        chk("ld_req", 64'(dm_req), 64'd1);
        chk("ld_addr", dm_addr, 64'h10);
        chk("ld_we", 64'(dm_we), 64'd0);
        chk("ld_req_stall", 64'(stall), 64'd1);
        tick();
        chk("ld_done_req", 64'(dm_req), 64'd0);
        chk("ld_done_stall", 64'(stall), 64'd0);
        chk("ld_rdata", readData_M, 64'hABCD);
        memRead_M = 1'b0;
        tick();
        chk("ld_idle_after", 64'(stall), 64'd0);

        // dm_ready outside REQ is ignored
        tick();
        chk("rdy_idle_req", 64'(dm_req), 64'd0);
        chk("rdy_idle_rdata", readData_M, 64'hABCD);

        // Branch resolution
        Branch_M = 1'b1; zero_M = 1'b1;
        #1;
        chk("br_taken", 64'(PCSrc_M), 64'd1);
        zero_M = 1'b0;
        #1;
        chk("br_not_taken", 64'(PCSrc_M), 64'd0);
        chk("br_stall", 64'(stall), 64'd0);
        Branch_M = 1'b0;

        // Store with three wait cycles
        dm_ready = 1'b0; memWrite_M = 1'b1; aluResult_M = 64'h8; writeData_M = 64'h5;
        #1;
        chk("st_idle_stall", 64'(stall), 64'd1);
        writeData_M = 64'h5;
        tick();
        chk("st_req1", 64'(dm_req), 64'd1);
        chk("st_we1", 64'(dm_we), 64'd1);
        chk("st_wdata1", dm_wdata, 64'h5);
        writeData_M = 64'hFF; aluResult_M = 64'h40;
        tick();
        chk("st_req2", 64'(dm_req), 64'd1);
        tick();
        chk("st_req3", 64'(dm_req), 64'd1);
        chk("st_stall3", 64'(stall), 64'd1);
        tick();
        chk("st_req4", 64'(dm_req), 64'd1);
        chk("st_we4", 64'(dm_we), 64'd1);
        chk("st_wdata4", dm_wdata, 64'h5);
        chk("st_addr4", dm_addr, 64'h8);
        dm_ready = 1'b1;
        tick();
        chk("st_done_stall", 64'(stall), 64'd0);
        chk("st_done_req", 64'(dm_req), 64'd0);
        chk("st_rdata_kept", readData_M, 64'hABCD);
        memWrite_M = 1'b0; dm_ready = 1'b0;
        tick();

        // Reset during the second wait cycle of a load
        memRead_M = 1'b1; aluResult_M = 64'h20; dm_rdata = 64'h77;
        tick();
        tick();
        chk("rr_req", 64'(dm_req), 64'd1);
        reset = 1'b0;
        #1;
        chk("rr_req_drop", 64'(dm_req), 64'd0);
        chk("rr_stall_drop", 64'(stall), 64'd0);
        chk("rr_rdata", readData_M, 64'h0);
        chk("rr_addr", dm_addr, 64'h0);
        memRead_M = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rr_idle_req", 64'(dm_req), 64'd0);
        chk("rr_idle_stall", 64'(stall), 64'd0);

        // Timeout: TIMEOUT-1 REQ cycles, then ERR
        memRead_M = 1'b1; aluResult_M = 64'h18; dm_ready = 1'b0;
        tick();
        chk("to_req1", 64'(dm_req), 64'd1);
        for (int i = 2; i <= int'(TIMEOUT) - 1; i++) begin
            tick();
            chk($sformatf("to_req%0d", i), 64'(dm_req), 64'd1);
        end
        tick();
        chk("to_err_req", 64'(dm_req), 64'd0);
        chk("to_err_flag", 64'(mem_err), 64'd1);
        chk("to_err_stall", 64'(stall), 64'd1);
        memRead_M = 1'b0;
        tick();
        chk("to_err_hold", 64'(mem_err), 64'd1);
        chk("to_err_rdata", readData_M, 64'h0);
        reset = 1'b0;
        #1;
        chk("to_rst_err", 64'(mem_err), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Misaligned load
        memRead_M = 1'b1; aluResult_M = 64'h3;
        #1;
        chk("mis_idle_stall", 64'(stall), 64'd1);
        tick();
        chk("mis_req", 64'(dm_req), 64'd0);
        chk("mis_err", 64'(mem_err), 64'd1);
        chk("mis_stall", 64'(stall), 64'd1);
        memRead_M = 1'b0;
        tick();
        tick();
        chk("mis_err_hold", 64'(mem_err), 64'd1);
        chk("mis_stall_hold", 64'(stall), 64'd1);
        chk("mis_req_hold", 64'(dm_req), 64'd0);
        reset = 1'b0;
        #1;
        chk("mis_rst_err", 64'(mem_err), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Read and write together is illegal
        memRead_M = 1'b1; memWrite_M = 1'b1; aluResult_M = 64'h0;
        tick();
        chk("both_req", 64'(dm_req), 64'd0);
        chk("both_err", 64'(mem_err), 64'd1);
        memRead_M = 1'b0; memWrite_M = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL provide parameter N, default 64, the datapath width in bits.
REQ-002 SHALL provide parameter TIMEOUT, default 16, the maximum number of cycles in REQ before an error is raised.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port memRead_M, input, 1 bit: the current instruction loads from data memory.
REQ-006 SHALL have port memWrite_M, input, 1 bit: the current instruction stores to data memory.
REQ-007 SHALL have port Branch_M, input, 1 bit: the current instruction is a conditional branch (CBZ).
REQ-008 SHALL have port zero_M, input, 1 bit: the zero flag from the execute stage.
REQ-009 SHALL have port aluResult_M, input, N bits: the byte address from the execute stage.
REQ-010 SHALL have port writeData_M, input, N bits: the store data from the execute stage.
REQ-011 SHALL have port PCSrc_M, output, 1 bit: branch taken.
REQ-012 SHALL have port readData_M, output, N bits: the load result.
REQ-013 SHALL have port stall, output, 1 bit: holds the PC and the upstream stage.
REQ-014 SHALL have port mem_err, output, 1 bit: sticky fault flag.
REQ-015 SHALL have port dm_req, output, 1 bit: request valid on the data-memory bus.
REQ-016 SHALL have port dm_we, output, 1 bit: 1 = write, 0 = read.
REQ-017 SHALL have port dm_addr, output, N bits: the request address.
REQ-018 SHALL have port dm_wdata, output, N bits: the request write data.
REQ-019 SHALL have port dm_ready, input, 1 bit: the memory accepts or completes the request.
REQ-020 SHALL have port dm_rdata, input, N bits: read data, valid when dm_ready=1 on a read.

Function
REQ-021 SHALL compute PCSrc_M = Branch_M & zero_M combinationally, independent of FSM state.
REQ-022 SHALL implement an FSM with states IDLE, REQ, DONE and ERR.
REQ-023 In IDLE, SHALL drive stall = memRead_M | memWrite_M combinationally and dm_req = 0.
REQ-024 In IDLE with exactly one of memRead_M or memWrite_M set and aluResult_M[2:0] == 0, SHALL at the clock edge latch dm_addr = aluResult_M, dm_wdata = writeData_M and dm_we = memWrite_M, clear the timeout counter, and go to REQ.
REQ-025 In IDLE with an access where aluResult_M[2:0] != 0, or with memRead_M and memWrite_M both 1, SHALL go to ERR and issue no bus request.
REQ-026 In IDLE with no access, SHALL remain in IDLE; all latched registers hold their values.
REQ-027 In REQ, SHALL drive dm_req = 1 and stall = 1, and hold dm_addr, dm_wdata and dm_we stable.
REQ-028 In REQ when dm_ready = 1 at the edge, SHALL go to DONE and, for a read only, load readData_M from dm_rdata.
REQ-029 In REQ when dm_ready = 0 at the edge, SHALL increment the counter; on reaching TIMEOUT-1 without dm_ready, SHALL go to ERR.
REQ-030 The minimum access latency SHALL be 2 cycles (IDLE→REQ→DONE), with stall high for exactly 2 cycles when memory is zero-wait.
REQ-031 In DONE, SHALL drive stall = 0 and dm_req = 0, so the pipeline advances at this edge, and then go unconditionally to IDLE.
REQ-032 The DONE→IDLE transition SHALL not start a new access in DONE itself, even when the inputs already show the next access.
REQ-033 readData_M SHALL hold its value until the next completed read; writes and errors SHALL leave it unchanged.
REQ-034 In ERR, SHALL drive mem_err = 1, stall = 1 and dm_req = 0, and stay in ERR until reset.
REQ-035 dm_ready asserted outside REQ SHALL be ignored.

Reset
REQ-036 While reset = 0, asynchronously, SHALL force state = IDLE, readData_M = 0, dm_addr = 0, dm_wdata = 0, dm_we = 0, counter = 0 and mem_err = 0; dm_req SHALL be 0 immediately.
REQ-037 A reset asserted mid-access (in REQ) SHALL abandon the request, with dm_req dropping asynchronously, and no readData_M update.
REQ-038 After reset deasserts, SHALL resume in IDLE on the first clock edge.

Verification
REQ-039 Load, zero-wait: memRead_M = 1, aluResult_M = 64'h10, dm_ready tied 1, dm_rdata = 64'hABCD → dm_req for 1 cycle with dm_addr = 64'h10 and dm_we = 0; stall high for 2 cycles; readData_M = 64'hABCD in DONE.
REQ-040 Store, 3 wait cycles: memWrite_M = 1, aluResult_M = 64'h8, writeData_M = 64'h5, dm_ready high on the 4th REQ cycle → dm_we = 1 and dm_wdata = 64'h5 held for 4 cycles; stall high for 5 cycles; readData_M unchanged.
REQ-041 Misaligned: memRead_M = 1, aluResult_M = 64'h3 → no dm_req; mem_err = 1 and stall = 1 from the next cycle, persisting until reset.
REQ-042 Timeout: memRead_M = 1, aligned address, dm_ready held 0 → ERR entered after TIMEOUT-1 REQ cycles, dm_req = 0, mem_err = 1.
REQ-043 Branch: Branch_M = 1 with zero_M = 1 → PCSrc_M = 1; with zero_M = 0 → PCSrc_M = 0; stall = 0 with no memory access.
REQ-044 Reset in REQ: pull reset low during the 2nd wait cycle → dm_req = 0 and stall = 0 immediately, readData_M = 0, state = IDLE.
